// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle mult/div sequencer that owns architectural HI/LO.
// It also raises the decode stall while HI/LO are not yet stable.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [31:0] a, b, a_nx, b_nx, hi_nx, lo_nx;
    logic sg, sg_nx;
    logic is_mul, is_div;
    logic [63:0] prod;
    logic [31:0] ua, ub, uq, ur, quo, rem;
    assign is_mul = (mdop == 3'b001) || (mdop == 3'b010);
    assign is_div = (mdop == 3'b011) || (mdop == 3'b100);
    assign busy   = (state != IDLE);
    assign stall  = md_use & (busy | (start & (is_mul | is_div)));
    // Sign-extending to 64 bits lets one unsigned multiplier serve both mult and multu.
    assign prod = {{32{sg & a[31]}}, a} * {{32{sg & b[31]}}, b};
    // Divide magnitudes, then restore signs; -2^31/-1 naturally wraps to 0x80000000.
    assign ua  = (sg & a[31]) ? -a : a;
    assign ub  = (sg & b[31]) ? -b : b;
    assign uq  = ua / ub;
    assign ur  = ua % ub;
    assign quo = (sg & (a[31] ^ b[31])) ? -uq : uq;
    assign rem = (sg & a[31]) ? -ur : ur;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        a_nx     = a;
        b_nx     = b;
        sg_nx    = sg;
        hi_nx    = hi;
        lo_nx    = lo;
        if (state == IDLE) begin
            if (start && (is_mul || is_div)) begin
                a_nx     = rs_val;
                b_nx     = rt_val;
                sg_nx    = (mdop == 3'b001) || (mdop == 3'b011);
                cnt_nx   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                state_nx = is_mul ? MUL : DIV;
            end
            if (start && mdop == 3'b101) hi_nx = rs_val;
            if (start && mdop == 3'b110) lo_nx = rs_val;
        end else begin
            cnt_nx = cnt - 1'b1;
            if (cnt == CW'(1)) begin
                state_nx = IDLE;
                if (state == MUL) {hi_nx, lo_nx} = prod;
                else if (b != 32'd0) begin
                    hi_nx = rem;
                    lo_nx = quo;
                end
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            a     <= '0;
            b     <= '0;
            sg    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            a     <= a_nx;
            b     <= b_nx;
            sg    <= sg_nx;
            hi    <= hi_nx;
            lo    <= lo_nx;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed bench with an arithmetic reference model checked every cycle.
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] rs_val, rt_val;
    logic        md_use;
    logic [31:0] hi, lo;
    logic        busy, stall;
    int checks = 0;
    int errors = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .mdop(mdop),
        .rs_val(rs_val), .rt_val(rt_val), .md_use(md_use),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    // Reference: {valid, hi, lo} of an operation straight from the arithmetic rules.
    function automatic logic [64:0] model_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint p;
        int q, r;
        case (op)
            3'd1: begin
                p = longint'($signed(x)) * longint'($signed(y));
                return {1'b1, p};
            end
            3'd2: begin
                p = longint'({32'b0, x}) * longint'({32'b0, y});
                return {1'b1, p};
            end
            3'd3: begin
                if (y == 32'd0) return '0;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {1'b1, 32'h0, 32'h80000000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {1'b1, r, q};
            end
            3'd4: begin
                if (y == 32'd0) return '0;
                return {1'b1, x % y, x / y};
            end
            default: return '0;
        endcase
    endfunction

    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_ok;
    int          m_rem;
    logic [64:0] res;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi <= 0; m_lo <= 0; m_rem <= 0; p_ok <= 0; p_hi <= 0; p_lo <= 0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1 && p_ok) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (start) begin
            res = model_op(mdop, rs_val, rt_val);
            if (mdop == 3'd1 || mdop == 3'd2) m_rem <= 5;
            if (mdop == 3'd3 || mdop == 3'd4) m_rem <= 10;
            if (mdop == 3'd5) m_hi <= rs_val;
            if (mdop == 3'd6) m_lo <= rs_val;
            p_ok <= res[64];
            p_hi <= res[63:32];
            p_lo <= res[31:0];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
            chk("cyc_busy", {31'b0, busy}, {31'b0, m_rem != 0});
            chk("cyc_stall", {31'b0, stall},
                {31'b0, md_use & ((m_rem != 0) | (start & mdop >= 3'd1 & mdop <= 3'd4))});
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        start = 1; mdop = op; rs_val = rs; rt_val = rt;
        @(posedge clk); #1;
        start = 0; mdop = 0;
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input int n, input logic [31:0] eh, input logic [31:0] el);
        issue(op, rs, rt);
        chk({nm, "_busy_first"}, {31'b0, busy}, 32'd1);
        repeat (n - 1) @(posedge clk);
        #1 chk({nm, "_busy_last"}, {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1 chk({nm, "_busy_done"}, {31'b0, busy}, 32'd0);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
    endtask

    initial begin
        reset = 1; start = 0; mdop = 0; rs_val = 0; rt_val = 0; md_use = 0;
        repeat (2) @(posedge clk);
        #1 chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        reset = 0;
        @(posedge clk); #1;
        run_op("mult", 3'd1, 32'hFFFFFFFF, 32'h2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'h2, 5, 32'h00000001, 32'hFFFFFFFE);
        run_op("div", 3'd3, 32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
        issue(3'd5, 32'h11, 0);
        issue(3'd6, 32'h22, 0);
        run_op("divu_zero", 3'd4, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        issue(3'd5, 32'h12345678, 0);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", {31'b0, busy}, 0);
        issue(3'd6, 32'h9ABCDEF0, 0);
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi", hi, 32'h12345678);
        chk("mtlo_busy", {31'b0, busy}, 0);
        start = 1; mdop = 3'd1; rs_val = 32'd3; rt_val = 32'd7; md_use = 1;
        #1 chk("stall_req", {31'b0, stall}, 1);
        @(posedge clk); #1;
        start = 0; mdop = 0; rs_val = 32'd100; rt_val = 32'd100;
        for (int i = 0; i < 5; i++) begin
            chk("stall_busy", {31'b0, stall}, 1);
            @(posedge clk); #1;
        end
        chk("stall_clear", {31'b0, stall}, 0);
        chk("opchg_hi", hi, 32'd0);
        chk("opchg_lo", lo, 32'd21);
        md_use = 0;
        run_op("b2b_mult", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'h0, 32'h1);
        issue(3'd5, 32'hAA, 0);
        issue(3'd3, 32'd100, 32'd7);
        repeat (2) @(posedge clk);
        #2 reset = 1;
        #1 chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        @(posedge clk); #1 reset = 0;
        repeat (12) @(posedge clk);
        #1 chk("postrst_busy", {31'b0, busy}, 0);
        chk("postrst_hi", hi, 0);
        chk("postrst_lo", lo, 0);
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller sitting beside the ALU in the EX stage of the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo requests, latches operands, sequences a fixed-latency busy window, and commits results to the architectural HI/LO registers. It also raises the stall request that holds any MDU-using instruction in decode until HI/LO are stable.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  EX-stage request valid
- mdop  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
- rt_val  in  32  forwarded rt operand (divisor / multiplier)
- md_use  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  operation in flight
- stall  out  1  freeze F/D, bubble into EX

## Operation
- FSM states: IDLE, MUL, DIV. Down-counter cnt, width enough for max(MULT_CYCLES, DIV_CYCLES).
- IDLE, start=1, mdop mult/multu: latch rs_val, rt_val, op; cnt<=MULT_CYCLES; -> MUL.
- IDLE, start=1, mdop div/divu: same with DIV_CYCLES; -> DIV.
- IDLE, start=1, mthi: hi<=rs_val same edge; mtlo: lo<=rs_val; stay IDLE.
- start with mdop 000/111: no effect.
- MUL/DIV: cnt decrements each edge; edge where cnt==1 commits HI/LO, -> IDLE.
- start while MUL/DIV: ignored (pipeline guarantees none via stall).
- busy = (state != IDLE), registered.
- stall = md_use & (busy | (start & mdop ∈ {001..100})), combinational.
- mult: {hi,lo} <= signed 32×32 -> 64-bit product. multu: unsigned.
- div: lo <= quotient truncated toward zero, hi <= remainder, sign of dividend. divu: unsigned.
- div, -2^31 / -1: lo=0x80000000, hi=0x00000000.
- Divisor 0 (div or divu): HI/LO unchanged, still occupies DIV_CYCLES.
- Operands come only from the latched copies; rs_val/rt_val changes during busy have no effect.

## Timing
- Reset (asynchronous, any time): state IDLE, cnt 0, busy 0, hi 0, lo 0; in-flight result discarded. stall follows md_use/start immediately.
- Start edge T0: busy=1 from T0 through edge T0+N (N=MULT_CYCLES or DIV_CYCLES); HI/LO new and busy=0 visible after edge T0+N.
- mthi/mtlo: new value visible after the start edge; busy stays 0.
- mfhi/mflo in D during busy: stall=1 every cycle until busy falls; the cycle busy=0 it reads the committed value.
- Back-to-back: a second mult may start on the first cycle busy=0.

## Test plan
- Reset mid-div (assert 3 cycles after div start) -> busy 0, hi=lo=0 immediately; no later commit.
- mult rs=0xFFFFFFFF rt=0x00000002 -> after 5 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div rs=0xFFFFFFF9 (−7) rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/2 -> lo=3, hi=1.
- div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; divu 5/0 with hi=0x11, lo=0x22 -> unchanged after 10 cycles.
- mthi rs=0x12345678 then mtlo rs=0x9ABCDEF0 on consecutive cycles -> hi/lo updated next edge each, busy never rises.
- mult start with md_use=1 same cycle -> stall=1 for that cycle plus 5 busy cycles, 0 thereafter; operand change during busy ignored.
